// File: rtl/lfsr_period_mon.sv
// Measures the cycle length of an upstream LFSR state stream using a visited-state bitmap.
// Optional idle timeout is compiled in with `define LFSR_MON_TIMEOUT_EN.
module lfsr_period_mon #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         valid,
  input  logic [W-1:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [W:0]   period,
  output logic         full_cov,
`ifdef LFSR_MON_TIMEOUT_EN
  output logic         timeout,
`endif
  output logic         tail_err
);
  localparam int CW = W + 1;
  localparam int NS = 1 << W;

  typedef enum logic [1:0] {IDLE, CAPTURE, MEASURE, DONE} state_t;

  state_t        state_q, state_d;
  logic [NS-1:0] bitmap_q, bitmap_d;
  logic [NS-1:0] sample_hot;
  logic [W-1:0]  ref_state_q, ref_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          full_cov_q, full_cov_d;
  logic          tail_err_q, tail_err_d;
  logic          seen;

`ifdef LFSR_MON_TIMEOUT_EN
  localparam int IW = W + 2;
  localparam logic [IW-1:0] IDLE_LAST = IW'((1 << (W + 1)) - 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`endif

  // One-hot decode of the incoming sample, shared by bitmap set and lookup.
  for (genvar gi = 0; gi < NS; gi++) begin : g_hot
    assign sample_hot[gi] = (state_in == W'(gi));
  end

  assign seen = |(bitmap_q & sample_hot);

  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    ref_state_d = ref_state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    full_cov_d  = full_cov_q;
    tail_err_d  = tail_err_q;
`ifdef LFSR_MON_TIMEOUT_EN
    idle_d      = idle_q;
    timeout_d   = timeout_q;
`endif
    if (start) begin
      bitmap_d   = '0;
      cnt_d      = '0;
      period_d   = '0;
      full_cov_d = 1'b0;
      tail_err_d = 1'b0;
      state_d    = CAPTURE;
`ifdef LFSR_MON_TIMEOUT_EN
      idle_d     = '0;
      timeout_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        CAPTURE: begin
          if (valid) begin
            ref_state_d = state_in;
            bitmap_d    = bitmap_q | sample_hot;
            cnt_d       = CW'(1);
            state_d     = MEASURE;
          end
        end
        MEASURE: begin
          if (valid) begin
            if (state_in == ref_state_q) begin
              period_d   = cnt_q;
              full_cov_d = &bitmap_q;
              tail_err_d = 1'b0;
              state_d    = DONE;
            end else if (seen) begin
              // A non-reference state came back first: tail or sub-cycle.
              period_d   = cnt_q;
              full_cov_d = 1'b0;
              tail_err_d = 1'b1;
              state_d    = DONE;
            end else begin
              bitmap_d = bitmap_q | sample_hot;
              cnt_d    = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
`ifdef LFSR_MON_TIMEOUT_EN
      if (valid) begin
        idle_d = '0;
      end else if (state_q == CAPTURE || state_q == MEASURE) begin
        if (idle_q == IDLE_LAST) begin
          state_d    = DONE;
          timeout_d  = 1'b1;
          period_d   = cnt_q;
          full_cov_d = 1'b0;
          tail_err_d = 1'b0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitmap_q    <= '0;
      ref_state_q <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      full_cov_q  <= 1'b0;
      tail_err_q  <= 1'b0;
`ifdef LFSR_MON_TIMEOUT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      ref_state_q <= ref_state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      full_cov_q  <= full_cov_d;
      tail_err_q  <= tail_err_d;
`ifdef LFSR_MON_TIMEOUT_EN
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign busy     = (state_q == CAPTURE) || (state_q == MEASURE);
  assign done     = (state_q == DONE);
  assign period   = period_q;
  assign full_cov = full_cov_q;
  assign tail_err = tail_err_q;
`ifdef LFSR_MON_TIMEOUT_EN
  assign timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_lfsr_period_mon.sv
// Self-checking bench for lfsr_period_mon (W=4): vector table, hand sequences, randomized trials.
// Timeout checks are included when LFSR_MON_TIMEOUT_EN is defined.
module tb_lfsr_period_mon;
  logic       clk = 1'b0;
  logic       rst, start, valid;
  logic [3:0] state_in;
  logic       busy, done, full_cov, tail_err;
  logic [4:0] period;
`ifdef LFSR_MON_TIMEOUT_EN
  logic       timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] seq[$];
  logic [3:0] db[16];

  typedef struct packed {
    logic [19:0][3:0] s;
    logic [4:0]       n;
    logic             toggle;
    logic [4:0]       exp_period;
    logic             exp_full;
    logic             exp_tail;
  } vec_t;

  vec_t vecs[5];

  lfsr_period_mon #(.W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .valid(valid),
    .state_in(state_in),
    .busy(busy),
    .done(done),
    .period(period),
    .full_cov(full_cov),
`ifdef LFSR_MON_TIMEOUT_EN
    .timeout(timeout),
`endif
    .tail_err(tail_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input int per, input bit full, input bit tail);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " period"}, 32'(period), 32'(per));
    check({tag, " full_cov"}, 32'(full_cov), 32'(full));
    check({tag, " tail_err"}, 32'(tail_err), 32'(tail));
`ifdef LFSR_MON_TIMEOUT_EN
    check({tag, " timeout"}, 32'(timeout), 32'd0);
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " period"}, 32'(period), 32'd0);
    check({tag, " full_cov"}, 32'(full_cov), 32'd0);
    check({tag, " tail_err"}, 32'(tail_err), 32'd0);
  endtask

  // Pulse start, then feed the first n entries of seq; gap_mode 1 = one idle cycle
  // before every sample, 2 = random 0..2 idle cycles.
  task automatic run_seq(input int n, input int gap_mode, input string tag);
    start = 1'b1; valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        valid = 1'b0; state_in = 4'($urandom);
        @(negedge clk);
      end
      if (i == n - 1) begin
        check({tag, " pre-close done"}, 32'(done), 32'd0);
        check({tag, " pre-close busy"}, 32'(busy), 32'd1);
      end
      valid = 1'b1; state_in = seq[i];
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  // Reference: first sample repeating an earlier one closes the measurement.
  task automatic model(output int per, output bit full, output bit tail, output int close_idx);
    per = 0; full = 1'b0; tail = 1'b0; close_idx = -1;
    for (int j = 1; j < seq.size() && close_idx < 0; j++) begin
      for (int k = 0; k < j; k++) begin
        if (seq[k] == seq[j] && close_idx < 0) begin
          close_idx = j;
          per  = j;
          tail = (k != 0);
          full = (k == 0) && (j == 16);
        end
      end
    end
  endtask

  initial begin
    logic [63:0] db_bits;
    logic [3:0]  x;
    int per, cidx;
    bit full, tail;
    logic [3:0] perm[16];

    db_bits = {4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
               4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    for (int i = 0; i < 16; i++) db[i] = db_bits[63 - 4*i -: 4];

    vecs[0] = '0;
    for (int i = 0; i < 16; i++) vecs[0].s[i] = db[i];
    vecs[0].s[16] = db[0];
    vecs[0].n = 5'd17; vecs[0].exp_period = 5'd16; vecs[0].exp_full = 1'b1;

    vecs[1] = '0;
    x = 4'h1;
    for (int i = 0; i < 16; i++) begin
      vecs[1].s[i] = x;
      x = {x[2:0], x[3] ^ x[2]};
    end
    vecs[1].n = 5'd16; vecs[1].exp_period = 5'd15;

    vecs[2] = '0;
    vecs[2].s[0] = 4'd1; vecs[2].s[1] = 4'd2; vecs[2].s[2] = 4'd3; vecs[2].s[3] = 4'd2;
    vecs[2].n = 5'd4; vecs[2].exp_period = 5'd3; vecs[2].exp_tail = 1'b1;

    vecs[3] = '0;
    vecs[3].n = 5'd2; vecs[3].exp_period = 5'd1;

    vecs[4] = vecs[0];
    vecs[4].toggle = 1'b1;

    rst = 1'b1; start = 1'b0; valid = 1'b0; state_in = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post-reset idle");

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      seq.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) seq.push_back(vecs[v].s[i]);
      run_seq(int'(vecs[v].n), vecs[v].toggle ? 1 : 0, tag);
      check_result(tag, int'(vecs[v].exp_period), vecs[v].exp_full, vecs[v].exp_tail);
      $display("[TB] %s period=%0d full_cov=%0b tail_err=%0b", tag, period, full_cov, tail_err);
      for (int k = 0; k < 3; k++) begin
        valid = 1'b1; state_in = 4'($urandom);
        @(negedge clk);
      end
      valid = 1'b0;
      check_result({tag, " hold"}, int'(vecs[v].exp_period), vecs[v].exp_full, vecs[v].exp_tail);
    end

    // rst in the middle of MEASURE, with start also high: abort to IDLE.
    seq.delete();
    for (int i = 0; i < 5; i++) seq.push_back(db[i]);
    run_seq(5, 0, "rst-mid");
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_idle("rst-mid after");
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; state_in = db[k];
      @(negedge clk);
    end
    valid = 1'b0;
    check_idle("rst-mid stays idle");
    $display("[TB] rst mid-measure busy=%0b done=%0b", busy, done);

    // start mid-MEASURE, with valid in the same cycle: that sample must not become ref.
    run_seq(5, 0, "restart");
    start = 1'b1; valid = 1'b1; state_in = 4'd5;
    @(negedge clk);
    start = 1'b0;
    check("restart busy", 32'(busy), 32'd1);
    check("restart period cleared", 32'(period), 32'd0);
    seq.delete();
    seq.push_back(4'd1); seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd2);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; state_in = seq[i];
      @(negedge clk);
    end
    valid = 1'b0;
    check_result("restart", 3, 1'b0, 1'b1);
    $display("[TB] restart period=%0d tail_err=%0b", period, tail_err);

`ifdef LFSR_MON_TIMEOUT_EN
    seq.delete();
    seq.push_back(4'd1); seq.push_back(4'd2); seq.push_back(4'd3);
    run_seq(3, 0, "timeout");
    valid = 1'b0;
    repeat (31) @(negedge clk);
    check("timeout early done", 32'(done), 32'd0);
    @(negedge clk);
    check("timeout done", 32'(done), 32'd1);
    check("timeout flag", 32'(timeout), 32'd1);
    check("timeout period", 32'(period), 32'd3);
    check("timeout full_cov", 32'(full_cov), 32'd0);
    check("timeout tail_err", 32'(tail_err), 32'd0);
    $display("[TB] timeout period=%0d timeout=%0b", period, timeout);
`else
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
    repeat (40) @(negedge clk);
    check("capture wait busy", 32'(busy), 32'd1);
    check("capture wait done", 32'(done), 32'd0);
    $display("[TB] capture wait busy=%0b done=%0b", busy, done);
`endif

    for (int t = 0; t < 40; t++) begin
      string tag;
      tag = $sformatf("rand%0d", t);
      seq.delete();
      if (t % 2 == 0) begin
        int hi;
        hi = (t % 4 == 0) ? 3 : 15;
        for (int i = 0; i < 18; i++) seq.push_back(4'($urandom_range(0, hi)));
      end else begin
        int k;
        for (int i = 0; i < 16; i++) perm[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
          int j;
          logic [3:0] tmp;
          j = int'($urandom_range(0, i));
          tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        k = (t % 8 == 1) ? 16 : int'($urandom_range(1, 16));
        for (int i = 0; i < k; i++) seq.push_back(perm[i]);
        seq.push_back(perm[0]);
      end
      model(per, full, tail, cidx);
      run_seq(cidx + 1, 2, tag);
      check_result(tag, per, full, tail);
      $display("[TB] %s period=%0d full_cov=%0b tail_err=%0b", tag, period, full_cov, tail_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
